// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider tile: widths, FSM state
// encoding and the bit positions of the bidirectional uio pins.
package divider_pkg;

  // Operand widths: 8-bit dividend (a multiplier product), 4-bit divisor.
  localparam int N_W = 8;
  localparam int D_W = 4;

  // Iteration counter width; it counts N_W steps from N_W-1 down to 0.
  localparam int CNT_W = 3;

  // uio_in / uio_out bit positions.
  localparam int UIO_DIVISOR_LSB = 0;
  localparam int UIO_START       = 4;
  localparam int UIO_SEL         = 5;
  localparam int UIO_BUSY        = 6;
  localparam int UIO_DONE        = 7;

  // Only busy and done are driven outward on the uio bus.
  localparam logic [7:0] UIO_OE_MASK = 8'b1100_0000;

  // Results reported for a zero divisor.
  localparam logic [N_W-1:0] DBZ_QUOTIENT  = '1;
  localparam logic [D_W-1:0] DBZ_REMAINDER = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : divider_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step
  import divider_pkg::*;
(
  input  logic [D_W-1:0] rem_i,
  input  logic           bit_i,
  input  logic [D_W-1:0] dvs_i,
  output logic [D_W:0]   rem_o,
  output logic           qbit_o
);

  logic [D_W:0] trial;
  logic [D_W:0] dvs_ext;

  // Trial subtraction; keep the shifted value when the divisor does not fit.
  always_comb begin
    trial   = {rem_i, bit_i};
    dvs_ext = {1'b0, dvs_i};
    if (trial >= dvs_ext) begin
      rem_o  = trial - dvs_ext;
      qbit_o = 1'b1;
    end else begin
      rem_o  = trial;
      qbit_o = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/tt_um_seq_divider_hhrb98.sv
// Sequential unsigned restoring divider tile (8-bit / 4-bit), one quotient
// bit per clock, wrapped in the Tiny Tapeout pin harness.
module tt_um_seq_divider_hhrb98
  import divider_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [N_W-1:0]     dvd_q, dvd_d;
  logic [D_W-1:0]     dvs_q, dvs_d;
  logic [D_W:0]       rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;

  logic [D_W-1:0]     divisor_in;
  logic               start_in;
  logic               sel_in;
  logic               start_ev;
  logic               accept;
  logic               zero_divisor;
  logic               last_step;
  logic [D_W:0]       step_rem;
  logic               step_qbit;
  logic               busy;
  logic               done;

  // rem_q[D_W] stays 0 because rem < divisor after every step.
  logic               unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:6], rem_q[D_W]};

  assign divisor_in   = uio_in[UIO_DIVISOR_LSB +: D_W];
  assign start_in     = uio_in[UIO_START];
  assign sel_in       = uio_in[UIO_SEL];
  assign start_ev     = ena && start_in && !start_q;
  assign accept       = start_ev && (state_q != RUN);
  assign zero_divisor = (divisor_in == '0);
  assign last_step    = (cnt_q == '0);

  div_step u_step (
    .rem_i  (rem_q[D_W-1:0]),
    .bit_i  (dvd_q[N_W-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; everything freezes while ena is low.
  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_d = zero_divisor ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_step) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs, decoded from registered state only.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next values: capture on an accepted start, step while running.
  always_comb begin
    start_d = start_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    if (ena) begin
      start_d = start_in;
      if (accept) begin
        dvs_d = divisor_in;
        cnt_d = CNT_W'(N_W - 1);
        if (zero_divisor) begin
          dvd_d = DBZ_QUOTIENT;
          rem_d = {1'b0, DBZ_REMAINDER};
          dbz_d = 1'b1;
        end else begin
          dvd_d = ui_in;
          rem_d = '0;
          dbz_d = 1'b0;
        end
      end else if (state_q == RUN) begin
        rem_d = step_rem;
        dvd_d = {dvd_q[N_W-2:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Pin muxing; the result select only steers uo_out.
  always_comb begin
    if (sel_in) begin
      uo_out = {3'b000, dbz_q, rem_q[D_W-1:0]};
    end else begin
      uo_out = dvd_q;
    end
    uio_out           = '0;
    uio_out[UIO_BUSY] = busy;
    uio_out[UIO_DONE] = done;
    uio_oe            = UIO_OE_MASK;
  end

endmodule : tt_um_seq_divider_hhrb98

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Directed, table-driven bench for the sequential divider tile.
module tb_tt_um_seq_divider_hhrb98;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_seq_divider_hhrb98 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;    // expected uo_out with sel=0
    logic [7:0] st;   // expected uo_out with sel=1
    int         lat;  // edges after the start edge until done
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Runs one division. pause_at/pulse_at (edge index after E0, -1 = off)
  // insert a 3-cycle ena drop or a start pulse during RUN.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input bit hold, input int pause_at, input int pulse_at,
                         output logic [7:0] q, output logic [7:0] st,
                         output int lat, output bit busy0, output bit done0,
                         output bit gap);
    @(negedge clk);
    ui_in  = a;
    uio_in = {2'b00, 1'b0, 1'b1, b};
    @(posedge clk);
    #1;
    lat   = 0;
    busy0 = uio_out[6];
    done0 = uio_out[7];
    gap   = 1'b0;
    if (!hold) uio_in[4] = 1'b0;
    while (!uio_out[7] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!uio_out[7] && !uio_out[6]) gap = 1'b1;
      if (lat == pause_at) ena = 1'b0;
      if (pause_at >= 0 && lat == pause_at + 3) ena = 1'b1;
      if (lat == pulse_at) begin
        ui_in  = 8'd50;
        uio_in = {2'b00, 1'b0, 1'b1, 4'd3};
      end
      if (pulse_at >= 0 && lat == pulse_at + 1) uio_in[4] = 1'b0;
    end
    uio_in[5] = 1'b0;
    #1 q = uo_out;
    uio_in[5] = 1'b1;
    #1 st = uo_out;
    uio_in[5] = 1'b0;
  endtask

  initial begin
    logic [7:0] q, st, a, p;
    logic [3:0] b;
    int         lat;
    bit         busy0, done0, gap, ok;

    vecs[0] = '{8'd200, 4'd13, 8'h0F, 8'h05, 8};
    vecs[1] = '{8'd255, 4'd1,  8'hFF, 8'h00, 8};
    vecs[2] = '{8'd7,   4'd9,  8'h00, 8'h07, 8};
    vecs[3] = '{8'd0,   4'd5,  8'h00, 8'h00, 8};
    vecs[4] = '{8'h5A,  4'd0,  8'hFF, 8'h1F, 0};
    vecs[5] = '{8'd100, 4'd7,  8'h0E, 8'h02, 8};
    vecs[6] = '{8'd225, 4'd15, 8'h0F, 8'h00, 8};
    vecs[7] = '{8'd128, 4'd3,  8'h2A, 8'h02, 8};
    vecs[8] = '{8'd1,   4'd15, 8'h00, 8'h01, 8};
    vecs[9] = '{8'd254, 4'd15, 8'h10, 8'h0E, 8};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, 8'hC0);
    uio_in[5] = 1'b1;
    #1 chk("reset status", uo_out, 8'h00);
    uio_in[5] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-RUN aborts immediately.
    @(negedge clk);
    ui_in  = 8'd200;
    uio_in = {4'b0001, 4'd13};
    @(posedge clk);
    #1 uio_in[4] = 1'b0;
    chk("abort busy before", uio_out[6], 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", uio_out[6], 0);
    chk("abort done", uio_out[7], 0);
    chk("abort quotient", uo_out, 8'h00);
    uio_in[5] = 1'b1;
    #1 chk("abort status", uo_out, 8'h00);
    uio_in[5] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("abort idle flags", uio_out, 8'h00);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].a, vecs[i].b, 1'b0, -1, -1, q, st, lat, busy0, done0, gap);
      chk($sformatf("vec%0d quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d status", i), st, vecs[i].st);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d busy after start", i), busy0, (vecs[i].b != 0) ? 1 : 0);
      chk($sformatf("vec%0d done after start", i), done0, (vecs[i].b == 0) ? 1 : 0);
      chk($sformatf("vec%0d busy gap", i), gap, 0);
      if (vecs[i].b == 0) begin
        @(posedge clk);
        #1 chk("dbz busy stays low", uio_out[6], 0);
      end
    end

    // Start held high through DONE does not restart.
    run_div(8'd200, 4'd13, 1'b1, -1, -1, q, st, lat, busy0, done0, gap);
    chk("hold latency", lat, 8);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 if (uio_out != 8'h80) ok = 1'b0;
    end
    chk("hold stays done", ok, 1);
    chk("hold quotient", uo_out, 8'h0F);
    @(negedge clk);
    uio_in[4] = 1'b0;

    // Start pulse during RUN is ignored.
    run_div(8'd100, 4'd7, 1'b0, -1, 2, q, st, lat, busy0, done0, gap);
    chk("pulse latency", lat, 8);
    chk("pulse quotient", q, 8'h0E);
    chk("pulse status", st, 8'h02);

    // ena low for 3 cycles mid-RUN delays completion by 3.
    run_div(8'd200, 4'd13, 1'b0, 2, -1, q, st, lat, busy0, done0, gap);
    chk("pause latency", lat, 11);
    chk("pause quotient", q, 8'h0F);
    chk("pause status", st, 8'h05);

    // Round trip against the multiplier: (a*b)/b == a, remainder 0.
    for (int ia = 1; ia <= 15; ia++) begin
      for (int ib = 1; ib <= 15; ib++) begin
        p = 8'(ia * ib);
        b = 4'(ib);
        run_div(p, b, 1'b0, -1, -1, q, st, lat, busy0, done0, gap);
        chk($sformatf("rt %0d/%0d q", p, ib), q, ia);
        chk($sformatf("rt %0d/%0d r", p, ib), st, 0);
      end
    end

    // Random pairs against / and %.
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom_range(255, 0));
      b = 4'($urandom_range(15, 1));
      run_div(a, b, 1'b0, -1, -1, q, st, lat, busy0, done0, gap);
      chk($sformatf("rnd %0d/%0d q", a, b), q, a / b);
      chk($sformatf("rnd %0d/%0d r", a, b), st, a % b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tt_um_seq_divider_hhrb98

// File: doc/tt_um_seq_divider_hhrb98.md
# tt_um_seq_divider_hhrb98

Sequential unsigned divider tile, the inverse of the team's 4x4 array multiplier tile. It takes an 8-bit dividend (a multiplier product) and a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder. It uses restoring division, one quotient bit per clock. It sits in the same Tiny Tapeout harness as the multiplier, so a bench can check that a product divided by one of its factors returns the other factor.

## Interface
- No parameters. Widths are fixed: dividend N=8, divisor D=4.
- Clock is `clk` and reset is `rst_n`. There is one clock, and reset is asynchronous and active-low.
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; when low, all registers hold
- ui_in  input  8  dividend
- uio_in  input  8  [3:0] divisor; [4] start; [5] result select (0: quotient, 1: status/remainder); [7:6] unused
- uo_out  output  8  sel=0: quotient[7:0]; sel=1: {3'b000, dbz, remainder[3:0]}
- uio_out  output  8  [6] busy; [7] done; [5:0] driven 0
- uio_oe  output  8  constant 8'b1100_0000

## Operation
- FSM states: IDLE, RUN, DONE.
- Registers:
  - start_q: previous start
  - dvd: 8-bit shift register, dividend in, quotient out
  - dvs: 4-bit divisor
  - rem: 5-bit partial remainder
  - cnt: 3-bit counter
  - dbz: divide-by-zero flag
- Start event: start=1 and start_q=0 at a rising edge with ena=1.
  - It is accepted only in IDLE or DONE, and ignored in RUN.
  - start_q is updated every enabled cycle.
- On an accepted start:
  - Capture dvd=ui_in, dvs=uio_in[3:0], rem=0, cnt=7.
  - Clear done and dbz.
  - If divisor=0: set dbz=1, quotient=8'hFF, remainder=4'hF, and go to DONE.
  - Otherwise go to RUN.
- Each RUN cycle:
  - t = {rem[3:0], dvd[7]}.
  - If t >= dvs: rem = t - dvs and the quotient bit is 1. Else rem = t and the quotient bit is 0.
  - dvd = {dvd[6:0], qbit}; cnt decrements.
  - When cnt=0, go to DONE.
- Invariant: rem < dvs <= 15 after every step, so 5 bits suffice.
- In DONE: quotient = dvd and remainder = rem[3:0]. Results hold until the next accepted start.
- The result select input is combinational on uo_out only and never affects state.
- When ena=0: everything freezes, including start_q, cnt and the FSM. Outputs keep their current values.

## Timing
- Reset values:
  - state=IDLE
  - all data registers, dbz, start_q = 0
  - uo_out=0 and uio_out=0
  - uio_oe=8'b1100_0000 at all times
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state with no combinational input path.
- Normal divide:
  - Start is sampled at edge E0; busy goes high after E0.
  - Iterations happen at E1..E8.
  - After E8: busy=0, done=1, results valid.
  - Total latency is 8 cycles from the sampling edge, with no gaps.
- Divide by zero: after E0, done=1, dbz=1, busy never asserts.
- A start held high is a single event; another start requires start low for at least one enabled cycle.
- A start event in DONE restarts immediately: done drops after the sampling edge and busy rises.
- Asserting rst_n mid-RUN aborts at once (asynchronous). No partial result remains visible.

## Structure
- Shared package `divider_pkg`:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - constants N_W=8, D_W=4
  - uio bit-index constants: DIVISOR_LSB=0, START=4, SEL=5, BUSY=6, DONE=7
- One sub-module `div_step`: combinational restoring step.
  - Inputs: rem[3:0], next dividend bit, divisor[3:0].
  - Outputs: new rem[4:0], qbit.
- The top level holds the FSM, the registers and the pin muxing.

## Test plan
- Reset mid-RUN: start 200/13, assert rst_n low at the 4th iteration. Required: busy=0, done=0, uo_out=0 immediately. After release the FSM is IDLE.
- 200/13 (0xC8/0xD): done exactly 8 cycles after the start edge. quotient=0x0F; with sel=1, uo_out=0x05.
- Edge cases:
  - 255/1: quotient 0xFF, remainder 0.
  - 7/9: quotient 0x00, remainder 7.
  - 0/5: quotient 0, remainder 0.
- Divide by zero, 0x5A/0: done one cycle after the start edge, busy never high. quotient 0xFF; with sel=1, uo_out=0x1F.
- Start handling:
  - Start held high through DONE: no restart.
  - New start pulse during RUN: ignored, result unchanged.
  - ena=0 for 3 cycles mid-RUN: completion is delayed by exactly 3 cycles with a correct result.
- Round-trip against the multiplier model: for all a,b in 1..15, dividing a*b by b gives quotient a and remainder 0. Plus 1000 random (dividend, divisor != 0) pairs checked against the / and % operators.
